// File: rtl/bar_handshake_rr_arbiter.sv
// bar_handshake_rr_arbiter: round-robin arbiter sharing one registered
// ready/valid operand slot among N_REQ requesters, forwarding the winner index.
module bar_handshake_rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int WIDTH = 5,
    localparam int ID_W = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESETN,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_in1,
    input  logic [N_REQ*WIDTH-1:0] req_in2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_in1,
    output logic [WIDTH-1:0]       out_in2,
    output logic [ID_W-1:0]        out_id,
    output logic [15:0]            xfer_count
);
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  ptr_nxt;
    logic [WIDTH-1:0] pay1;
    logic [WIDTH-1:0] pay2;
    logic             slot_free;
    logic             any_valid;
    logic             load;

    assign slot_free = !out_valid || out_ready;
    assign any_valid = |req_valid;
    assign load      = slot_free && any_valid;
    assign ptr_nxt   = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
    // reset gating keeps ready low while the slot is held in reset
    assign req_ready = (load && ASYNCRESETN) ? (N_REQ'(1) << win) : '0;

    // scanning downward lets the candidate closest to ptr overwrite the others
    always_comb begin
        win  = ptr;
        pay1 = '0;
        pay2 = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (req_valid[ID_W'((int'(ptr) + k) % N_REQ)]) win = ID_W'((int'(ptr) + k) % N_REQ);
        for (int i = 0; i < N_REQ; i++)
            if (win == ID_W'(i)) begin
                pay1 = req_in1[i*WIDTH +: WIDTH];
                pay2 = req_in2[i*WIDTH +: WIDTH];
            end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            out_valid  <= 1'b0;
            out_in1    <= '0;
            out_in2    <= '0;
            out_id     <= '0;
            ptr        <= '0;
            xfer_count <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_in1   <= pay1;
                out_in2   <= pay2;
                out_id    <= win;
                ptr       <= ptr_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready) xfer_count <= xfer_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_bar_handshake_rr_arbiter.sv
// tb_bar_handshake_rr_arbiter: directed plan steps plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_bar_handshake_rr_arbiter;
    localparam int N  = 3;
    localparam int W  = 5;
    localparam int IW = 2;

    logic           CLK = 1'b0;
    logic           ASYNCRESETN;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_in1;
    logic [N*W-1:0] req_in2;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_in1;
    logic [W-1:0]   out_in2;
    logic [IW-1:0]  out_id;
    logic [15:0]    xfer_count;

    logic [W-1:0] p1 [N];
    logic [W-1:0] p2 [N];
    logic [N-1:0] acc;

    int checks = 0;
    int failures = 0;

    bit m_valid;
    int m_in1, m_in2, m_id, m_ptr, m_cnt;
    int waitc [N];

    bar_handshake_rr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_in1(out_in1), .out_in2(out_in2),
        .out_id(out_id), .xfer_count(xfer_count)
    );

    always #5 CLK = ~CLK;

    always_comb
        for (int i = 0; i < N; i++) begin
            req_in1[i*W +: W] = p1[i];
            req_in2[i*W +: W] = p2[i];
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_in1 = 0;
        m_in2 = 0;
        m_id = 0;
        m_ptr = 0;
        m_cnt = 0;
        for (int i = 0; i < N; i++) waitc[i] = 0;
    endtask

    // one clock: check grant before the edge, then advance model and check the slot
    task automatic cycle(output logic [N-1:0] a);
        int w;
        bit ld;
        logic [N-1:0] er;
        logic [N-1:0] v;
        int c1, c2;
        #1;
        v  = req_valid;
        w  = winner(m_ptr, v);
        ld = (!m_valid || out_ready) && (w >= 0);
        er = '0;
        if (ld) er[w] = 1'b1;
        c1 = (w >= 0) ? int'(p1[w]) : 0;
        c2 = (w >= 0) ? int'(p2[w]) : 0;
        chk("req_ready", req_ready, er);
        a = er;
        @(posedge CLK);
        #1;
        if (m_valid && out_ready) m_cnt = (m_cnt + 1) % 65536;
        if (ld) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] || i == w) waitc[i] = 0;
                else waitc[i]++;
                if (v[i]) chk("fairness", 32'(waitc[i] < N), 32'd1);
            end
            m_valid = 1;
            m_in1 = c1;
            m_in2 = c2;
            m_id = w;
            m_ptr = (w + 1) % N;
        end else if (out_ready) begin
            m_valid = 0;
        end
        chk("out_valid", out_valid, m_valid);
        chk("out_id", out_id, m_id);
        chk("out_in1", out_in1, m_in1);
        chk("out_in2", out_in2, m_in2);
        chk("xfer_count", xfer_count, m_cnt);
    endtask

    initial begin
        ASYNCRESETN = 1'b0;
        req_valid = '1;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            p1[i] = W'(i + 1);
            p2[i] = W'(i + 10);
        end
        model_reset();
        #12;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_in1", out_in1, 0);
        chk("rst_out_in2", out_in2, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_xfer_count", xfer_count, 0);
        ASYNCRESETN = 1'b1;
        out_ready = 1'b1;

        for (int k = 0; k < 6; k++) begin
            cycle(acc);
            chk("cont_id", out_id, k % 3);
            chk("cont_in1", out_in1, k % 3 + 1);
        end
        cycle(acc);
        chk("cont_count6", xfer_count, 6);

        cycle(acc);
        chk("bp_load_id", out_id, 1);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle(acc);
            chk("bp_ready_zero", acc, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_in1", out_in1, 2);
            chk("bp_in2", out_in2, 11);
        end
        out_ready = 1'b1;
        cycle(acc);
        chk("bp_release_grant", acc, 3'b100);
        chk("bp_release_id", out_id, 2);

        req_valid = 3'b001;
        cycle(acc);
        chk("skip_setup_id", out_id, 0);
        req_valid = 3'b101;
        cycle(acc);
        chk("skip_first", acc, 3'b100);
        chk("skip_first_id", out_id, 2);
        req_valid = 3'b001;
        cycle(acc);
        chk("skip_second", acc, 3'b001);
        chk("skip_second_id", out_id, 0);

        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++) begin
                if (acc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    p1[i] = W'($urandom);
                    p2[i] = W'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle(acc);
        end

        req_valid = '1;
        out_ready = 1'b0;
        cycle(acc);
        chk("mid_valid_before", out_valid, 1);
        #3;
        ASYNCRESETN = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", xfer_count, 0);
        chk("mid_rst_ready", req_ready, 0);
        model_reset();
        #2;
        ASYNCRESETN = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            p1[i] = W'(i + 1);
            p2[i] = W'(i + 10);
        end
        cycle(acc);
        chk("mid_first_grant", acc, 3'b001);
        chk("mid_first_id", out_id, 0);

        for (int k = 1; k <= 65537; k++) begin
            @(posedge CLK);
            #1;
            if (k == 65535) chk("wrap_ffff", xfer_count, 16'hFFFF);
            if (k == 65536) chk("wrap_zero", xfer_count, 0);
            if (k == 65537) chk("wrap_one", xfer_count, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
